// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception controller: cause codes, FSM encoding
// and the default handler entry point.
package exc_ctrl_pkg;

    localparam logic [4:0] CAUSE_INT  = 5'd0;
    localparam logic [4:0] CAUSE_SYS  = 5'd8;
    localparam logic [4:0] CAUSE_ILL  = 5'd10;
    localparam logic [4:0] CAUSE_PRIV = 5'd11;
    localparam logic [4:0] CAUSE_OVF  = 5'd12;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam logic [31:0] VECTOR_ADDR_DEF = 32'h0000_0080;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_EXC,
        EV_RFE
    } ev_kind_e;

endpackage

// File: rtl/exc_ctrl_if.sv
// Pipeline/status-register side of the exception controller: EX-stage faults,
// interrupt lines, status feedback, and the pulses/redirect it produces.
interface exc_ctrl_if #(
    parameter int NUM_IRQ = 6
);
    logic [NUM_IRQ-1:0] irq;
    logic               IE_c;
    logic               s_u_c;
    logic               ex_valid;
    logic [31:0]        ex_pc;
    logic               ex_illegal;
    logic               ex_priv;
    logic               ex_ovf;
    logic               ex_syscall;
    logic               ex_rfe;

    logic               exception;
    logic               rfe;
    logic               flush;
    logic               pc_redirect;
    logic [31:0]        redirect_pc;
    logic [31:0]        epc;
    logic [4:0]         cause;
    logic [NUM_IRQ-1:0] irq_pending;

    modport master (
        output irq, IE_c, s_u_c, ex_valid, ex_pc, ex_illegal, ex_priv,
               ex_ovf, ex_syscall, ex_rfe,
        input  exception, rfe, flush, pc_redirect, redirect_pc, epc, cause,
               irq_pending
    );

    modport slave (
        input  irq, IE_c, s_u_c, ex_valid, ex_pc, ex_illegal, ex_priv,
               ex_ovf, ex_syscall, ex_rfe,
        output exception, rfe, flush, pc_redirect, redirect_pc, epc, cause,
               irq_pending
    );
endinterface

// File: rtl/exc_ctrl_irq_sync.sv
// Two-flop synchroniser for a bus of independent level-sensitive lines.
module exc_ctrl_irq_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: prioritises EX-stage faults and interrupts,
// captures EPC/cause, and issues exception/rfe pulses plus flush and redirect.
//
// state | meaning
// IDLE  | events evaluated on ex_valid cycles
// FLUSH | flush asserted, all inputs ignored
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter int          NUM_IRQ      = 6,
    parameter logic [31:0] VECTOR_ADDR  = VECTOR_ADDR_DEF,
    parameter int          FLUSH_CYCLES = 2
) (
    input logic       clk,
    input logic       rst,
    exc_ctrl_if.slave bus
);
    localparam logic [2:0] CNT_LAST = 3'(FLUSH_CYCLES - 1);

    logic [0:0]         state;
    logic [2:0]         cnt;
    logic               exception_q;
    logic               rfe_q;
    logic               flush_q;
    logic               redirect_q;
    logic [31:0]        redirect_pc_q;
    logic [31:0]        epc_q;
    logic [4:0]         cause_q;
    logic [NUM_IRQ-1:0] pending;
    ev_kind_e           ev_kind;
    logic [4:0]         ev_code;

    exc_ctrl_irq_sync #(.WIDTH(NUM_IRQ)) u_irq_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.irq),
        .q   (pending)
    );

    always_comb begin
        ev_kind = EV_NONE;
        ev_code = CAUSE_INT;
        if (state == ST_IDLE && bus.ex_valid) begin
            if (bus.ex_illegal) begin
                ev_kind = EV_EXC;
                ev_code = CAUSE_ILL;
            end else if ((bus.ex_priv || bus.ex_rfe) && !bus.s_u_c) begin
                ev_kind = EV_EXC;
                ev_code = CAUSE_PRIV;
            end else if (bus.ex_ovf) begin
                ev_kind = EV_EXC;
                ev_code = CAUSE_OVF;
            end else if (bus.ex_syscall) begin
                ev_kind = EV_EXC;
                ev_code = CAUSE_SYS;
            end else if ((|pending) && bus.IE_c) begin
                ev_kind = EV_EXC;
                ev_code = CAUSE_INT;
            end else if (bus.ex_rfe) begin
                ev_kind = EV_RFE;
            end
        end
    end

    // The final flush cycle is spent in IDLE so the next event can be decided
    // FLUSH_CYCLES edges after the previous one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            exception_q   <= 1'b0;
            rfe_q         <= 1'b0;
            flush_q       <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            epc_q         <= '0;
            cause_q       <= '0;
        end else begin
            exception_q <= 1'b0;
            rfe_q       <= 1'b0;
            redirect_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    flush_q <= 1'b0;
                    if (ev_kind != EV_NONE) begin
                        flush_q    <= 1'b1;
                        redirect_q <= 1'b1;
                        cnt        <= '0;
                        state      <= (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_IDLE;
                        if (ev_kind == EV_EXC) begin
                            exception_q   <= 1'b1;
                            redirect_pc_q <= VECTOR_ADDR;
                            epc_q         <= bus.ex_pc;
                            cause_q       <= ev_code;
                        end else begin
                            rfe_q         <= 1'b1;
                            redirect_pc_q <= epc_q;
                        end
                    end
                end
                default: begin
                    cnt <= cnt + 3'd1;
                    if (cnt + 3'd1 == CNT_LAST) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.exception   = exception_q;
    assign bus.rfe         = rfe_q;
    assign bus.flush       = flush_q;
    assign bus.pc_redirect = redirect_q;
    assign bus.redirect_pc = redirect_pc_q;
    assign bus.epc         = epc_q;
    assign bus.cause       = cause_q;
    assign bus.irq_pending = pending;
endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed vector table, hand-written irq/reset sequences,
// and randomized traffic checked against a cycle-level behavioural model.
module tb_exc_ctrl;
    localparam int          NUM_IRQ = 6;
    localparam int          FC      = 2;
    localparam logic [31:0] VEC     = 32'h0000_0080;

    logic clk = 1'b0;
    logic rst = 1'b0;

    exc_ctrl_if #(.NUM_IRQ(NUM_IRQ)) bus ();

    exc_ctrl #(.NUM_IRQ(NUM_IRQ), .VECTOR_ADDR(VEC), .FLUSH_CYCLES(FC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v, ill, pr, ov, sy, rf, su;
        logic [31:0] pc;
        bit          e, r, f, rd;
        logic [31:0] rpc, epc;
        logic [4:0]  c;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // behavioural model state
    int                 m_ign, m_fl;
    bit                 m_exc, m_rfe, m_redir;
    logic [31:0]        m_rpc, m_epc;
    logic [4:0]         m_cause;
    logic [NUM_IRQ-1:0] m_p1, m_p2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, ill, pr, ov, sy, rf, su, ie,
                         input logic [NUM_IRQ-1:0] irq, input logic [31:0] pc);
        bus.ex_valid = v;   bus.ex_illegal = ill; bus.ex_priv = pr;
        bus.ex_ovf = ov;    bus.ex_syscall = sy;  bus.ex_rfe = rf;
        bus.s_u_c = su;     bus.IE_c = ie;        bus.irq = irq;
        bus.ex_pc = pc;
    endtask

    task automatic idle_in(input logic [NUM_IRQ-1:0] irq);
        drive(0, 0, 0, 0, 0, 0, 1, 1, irq, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input bit e, r, f, rd,
                             input logic [31:0] rpc, epc, input logic [4:0] c);
        check({tag, " exception"},   32'(bus.exception),   32'(e));
        check({tag, " rfe"},         32'(bus.rfe),         32'(r));
        check({tag, " flush"},       32'(bus.flush),       32'(f));
        check({tag, " pc_redirect"}, 32'(bus.pc_redirect), 32'(rd));
        check({tag, " redirect_pc"}, bus.redirect_pc,      rpc);
        check({tag, " epc"},         bus.epc,              epc);
        check({tag, " cause"},       32'(bus.cause),       32'(c));
    endtask

    function automatic vec_t mk(bit v, ill, pr, ov, sy, rf, su, logic [31:0] pc,
                                bit e, r, f, rd, logic [31:0] rpc, epc, logic [4:0] c);
        vec_t t;
        t.v = v; t.ill = ill; t.pr = pr; t.ov = ov; t.sy = sy; t.rf = rf; t.su = su;
        t.pc = pc; t.e = e; t.r = r; t.f = f; t.rd = rd; t.rpc = rpc; t.epc = epc; t.c = c;
        return t;
    endfunction

    function automatic vec_t nop(bit f, logic [31:0] rpc, epc, logic [4:0] c);
        return mk(0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, f, 0, rpc, epc, c);
    endfunction

    task automatic model_reset();
        m_ign = 0; m_fl = 0; m_exc = 0; m_rfe = 0; m_redir = 0;
        m_rpc = '0; m_epc = '0; m_cause = '0; m_p1 = '0; m_p2 = '0;
    endtask

    // Predicts outputs after the next rising edge from the inputs now applied.
    task automatic model_step();
        bit allowed;
        int code;
        bit ret;
        allowed = (m_ign == 0);
        code = -1;
        ret = 0;
        m_exc = 0; m_rfe = 0; m_redir = 0;
        if (m_ign > 0) m_ign--;
        if (m_fl > 0) m_fl--;
        if (allowed && bus.ex_valid) begin
            if (bus.ex_illegal)                     code = 10;
            else if (bus.ex_priv && !bus.s_u_c)     code = 11;
            else if (bus.ex_rfe && !bus.s_u_c)      code = 11;
            else if (bus.ex_ovf)                    code = 12;
            else if (bus.ex_syscall)                code = 8;
            else if (bus.IE_c && m_p2 != '0)        code = 0;
            else if (bus.ex_rfe)                    ret = 1;
        end
        if (code >= 0) begin
            m_exc = 1; m_redir = 1; m_rpc = VEC; m_epc = bus.ex_pc;
            m_cause = 5'(code); m_fl = FC; m_ign = FC - 1;
        end else if (ret) begin
            m_rfe = 1; m_redir = 1; m_rpc = m_epc; m_fl = FC; m_ign = FC - 1;
        end
        m_p2 = m_p1;
        m_p1 = bus.irq;
    endtask

    initial begin
        vec_t tbl[$];
        logic [NUM_IRQ-1:0] irq_r;

        idle_in('0);
        rst = 1'b0;

        // held in reset with inputs toggling
        for (int i = 0; i < 5; i++) begin
            drive(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1, 6'($urandom), $urandom);
            tick();
            check_out($sformatf("rst%0d", i), 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
            check($sformatf("rst%0d irq_pending", i), 32'(bus.irq_pending), 32'h0);
        end
        idle_in('0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("post_rst%0d", i), 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        end

        tbl.push_back(mk(1,0,0,1,0,0,1, 32'h1040, 1,0,1,1, VEC, 32'h1040, 12));
        tbl.push_back(mk(1,0,0,0,1,0,1, 32'h1044, 0,0,1,0, VEC, 32'h1040, 12));
        tbl.push_back(nop(0, VEC, 32'h1040, 12));
        tbl.push_back(mk(1,0,0,0,0,1,1, 32'h0084, 0,1,1,1, 32'h1040, 32'h1040, 12));
        tbl.push_back(mk(1,0,0,0,0,1,1, 32'h0088, 0,0,1,0, 32'h1040, 32'h1040, 12));
        tbl.push_back(nop(0, 32'h1040, 32'h1040, 12));
        tbl.push_back(mk(1,0,0,0,0,1,0, 32'h0300, 1,0,1,1, VEC, 32'h0300, 11));
        tbl.push_back(nop(1, VEC, 32'h0300, 11));
        tbl.push_back(nop(0, VEC, 32'h0300, 11));
        tbl.push_back(mk(1,0,1,0,0,0,1, 32'h0400, 0,0,0,0, VEC, 32'h0300, 11));
        tbl.push_back(mk(1,0,1,0,0,0,0, 32'h0404, 1,0,1,1, VEC, 32'h0404, 11));
        tbl.push_back(nop(1, VEC, 32'h0404, 11));
        tbl.push_back(nop(0, VEC, 32'h0404, 11));
        tbl.push_back(mk(1,1,1,1,1,0,1, 32'h0500, 1,0,1,1, VEC, 32'h0500, 10));
        tbl.push_back(nop(1, VEC, 32'h0500, 10));
        tbl.push_back(nop(0, VEC, 32'h0500, 10));
        tbl.push_back(mk(0,1,0,0,1,0,1, 32'h0580, 0,0,0,0, VEC, 32'h0500, 10));
        tbl.push_back(mk(1,0,0,0,1,0,1, 32'h0600, 1,0,1,1, VEC, 32'h0600, 8));
        tbl.push_back(nop(1, VEC, 32'h0600, 8));
        tbl.push_back(nop(0, VEC, 32'h0600, 8));
        tbl.push_back(mk(1,0,0,1,1,0,1, 32'h0700, 1,0,1,1, VEC, 32'h0700, 12));
        tbl.push_back(nop(1, VEC, 32'h0700, 12));
        tbl.push_back(mk(1,0,0,0,1,0,1, 32'h0704, 1,0,1,1, VEC, 32'h0704, 8));
        tbl.push_back(nop(1, VEC, 32'h0704, 8));
        tbl.push_back(nop(0, VEC, 32'h0704, 8));
        tbl.push_back(mk(1,0,0,0,0,1,1, 32'h0708, 0,1,1,1, 32'h0704, 32'h0704, 8));
        tbl.push_back(nop(1, 32'h0704, 32'h0704, 8));
        tbl.push_back(nop(0, 32'h0704, 32'h0704, 8));

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].ill, tbl[i].pr, tbl[i].ov, tbl[i].sy, tbl[i].rf,
                  tbl[i].su, 1, '0, tbl[i].pc);
            tick();
            check_out($sformatf("row%0d", i), tbl[i].e, tbl[i].r, tbl[i].f, tbl[i].rd,
                      tbl[i].rpc, tbl[i].epc, tbl[i].c);
        end

        // masked interrupt, then unmasked
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 0, 0, 0, 0, 1, 0, 6'b001000, 32'h1000 + 32'(i * 4));
            tick();
            check($sformatf("masked%0d exception", i), 32'(bus.exception), 32'h0);
        end
        check("masked irq_pending", 32'(bus.irq_pending), 32'h08);
        drive(1, 0, 0, 0, 0, 0, 1, 1, 6'b001000, 32'h0200);
        tick();
        check_out("unmasked", 1, 0, 1, 1, VEC, 32'h0200, 5'd0);
        idle_in('0);
        repeat (4) tick();
        check("irq drop pending", 32'(bus.irq_pending), 32'h0);
        check("irq drop flush", 32'(bus.flush), 32'h0);

        // fault coincident with pending interrupt; interrupt taken after flush
        idle_in(6'b000010);
        repeat (2) tick();
        check("simul pending", 32'(bus.irq_pending), 32'h02);
        drive(1, 1, 0, 0, 1, 0, 1, 1, 6'b000010, 32'h0900);
        tick();
        check_out("simul fault", 1, 0, 1, 1, VEC, 32'h0900, 5'd10);
        drive(1, 0, 0, 0, 0, 0, 1, 1, 6'b000010, 32'h0904);
        tick();
        check_out("simul flush", 0, 0, 1, 0, VEC, 32'h0900, 5'd10);
        drive(1, 0, 0, 0, 0, 0, 1, 1, 6'b000010, 32'h0908);
        tick();
        check_out("simul irq", 1, 0, 1, 1, VEC, 32'h0908, 5'd0);
        idle_in('0);
        repeat (4) tick();

        // reset asserted mid-flush
        drive(1, 0, 0, 1, 0, 0, 1, 1, '0, 32'h0A00);
        tick();
        check("midrst pre flush", 32'(bus.flush), 32'h1);
        idle_in('0);
        #2 rst = 1'b0;
        #1;
        check_out("midrst async", 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("midrst post%0d", i), 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        end

        // randomized traffic against the model
        @(negedge clk);
        rst = 1'b0;
        idle_in('0);
        tick();
        rst = 1'b1;
        model_reset();
        irq_r = '0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0)
                irq_r = ($urandom_range(0, 2) == 0) ? NUM_IRQ'($urandom) : '0;
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                  1'($urandom), $urandom_range(0, 3) != 0, irq_r, $urandom & 32'hFFFF_FFFC);
            model_step();
            tick();
            check_out($sformatf("rnd%0d", i), m_exc, m_rfe, m_fl > 0, m_redir,
                      m_rpc, m_epc, m_cause);
            check($sformatf("rnd%0d irq_pending", i), 32'(bus.irq_pending), 32'(m_p2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt controller that sits directly upstream of the status register.
- Collects synchronous faults from the EX stage and external interrupt lines, then prioritises them.
- Captures EPC and cause, and issues the one-cycle `exception` / `rfe` pulses that the status register consumes.
- Consumes the status register's `IE_c` and `s_u_c` outputs for gating, and drives pipeline flush plus PC redirect.

Parameters:
- NUM_IRQ, 6, number of external interrupt lines
- VECTOR_ADDR, 32'h0000_0080, handler entry PC
- FLUSH_CYCLES, 2, cycles `flush` stays asserted per taken event (1..7)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset (single clock domain; reset asynchronous, active-low)
- irq  in  NUM_IRQ  level-sensitive external interrupt requests, asynchronous to clk
- IE_c  in  1  current interrupt enable, from status register
- s_u_c  in  1  current mode, 1 = supervisor, 0 = user
- ex_valid  in  1  EX-stage instruction valid
- ex_pc  in  32  PC of EX-stage instruction
- ex_illegal  in  1  undefined opcode
- ex_priv  in  1  privileged instruction (excluding rfe)
- ex_ovf  in  1  arithmetic overflow
- ex_syscall  in  1  syscall instruction
- ex_rfe  in  1  rfe instruction in EX
- exception  out  1  one-cycle pulse to status register
- rfe  out  1  one-cycle pulse to status register
- flush  out  1  kill IF/ID/EX contents
- pc_redirect  out  1  one-cycle pulse: fetch from redirect_pc
- redirect_pc  out  32  target PC, valid with pc_redirect
- epc  out  32  PC of the faulting or interrupted instruction
- cause  out  5  exception code of the last taken event
- irq_pending  out  NUM_IRQ  synchronised irq lines

Behaviour:
- Reset (rst=0, asynchronous):
  - exception, rfe, flush, pc_redirect, irq_pending = 0
  - redirect_pc, epc = 0; cause = 0
  - FSM = IDLE; flush counter = 0
- irq synchronisation: two-flop synchroniser per line; irq_pending = second-stage flops (2-cycle latency).
- FSM states: IDLE, FLUSH.
  - Events are evaluated only in IDLE, and only on cycles with ex_valid=1.
  - In FLUSH, all inputs are ignored (no new event, no rfe).
- Priority in IDLE with ex_valid=1, highest first:
  1. ex_illegal: cause 10
  2. ex_priv with s_u_c=0: cause 11
  3. ex_rfe with s_u_c=0: cause 11
  4. ex_ovf: cause 12
  5. ex_syscall: cause 8
  6. interrupt (|irq_pending with IE_c=1): cause 0
  7. ex_rfe with s_u_c=1: return
- ex_priv with s_u_c=1 is no event.
- Taken exception or interrupt, decided at edge N; effective from cycle N+1:
  - exception=1 and pc_redirect=1 for exactly one cycle.
  - redirect_pc = VECTOR_ADDR; epc = ex_pc; cause = code.
  - flush=1 for FLUSH_CYCLES cycles starting N+1; FSM = FLUSH.
- Return (rfe), from cycle N+1:
  - rfe=1 and pc_redirect=1 for one cycle.
  - redirect_pc = epc; epc and cause unchanged.
  - flush for FLUSH_CYCLES cycles; FSM = FLUSH.
- FLUSH to IDLE when the counter reaches FLUSH_CYCLES-1. The earliest next event is decided at edge N+FLUSH_CYCLES.
- exception and rfe are never high in the same cycle.
  - They are driven directly from flops (the status register is edge-triggered on them; no glitches).
- Interrupt with IE_c=0: not taken; line stays pending and is taken on the first eligible IDLE cycle after IE_c returns to 1.
- A fault coincident with a pending interrupt: the fault wins. The interrupt stays pending and is taken later if still asserted.
- Reset asserted mid-FLUSH: all outputs clear immediately; no partial pulse is completed after reset release.

Decomposition:
- Shared package holds:
  - cause codes CAUSE_INT=0, CAUSE_SYS=8, CAUSE_ILL=10, CAUSE_PRIV=11, CAUSE_OVF=12
  - FSM state encoding
  - VECTOR_ADDR default
- One sub-module: irq_sync (parameterised-width two-flop synchroniser, active-low async reset).
- Priority encoder stays inline.

Test Plan:
- Reset check: hold rst=0 with all inputs toggling -> all outputs 0; release rst -> still 0 until an event.
- Overflow: ex_valid=1, ex_ovf=1, ex_pc=32'h0000_1040 at edge N -> at N+1: exception=1, pc_redirect=1, redirect_pc=32'h80, epc=32'h1040, cause=12; flush high N+1..N+2; exception low at N+2.
- Masked then unmasked interrupt: irq[3]=1, IE_c=0 -> no exception for 10 cycles; IE_c=1 with ex_valid=1, ex_pc=32'h200 -> exception pulse, cause=0, epc=32'h200.
- Simultaneous events: ex_illegal=1, ex_syscall=1, irq_pending≠0, IE_c=1 -> single exception pulse, cause=10; interrupt taken at the first IDLE valid cycle after flush ends.
- rfe in both modes: after epc=32'h1040, ex_rfe=1 with s_u_c=1 -> rfe pulse, redirect_pc=32'h1040, exception=0; repeat with s_u_c=0 -> exception, cause=11, rfe stays 0.
- Mid-flush behaviour: ex_syscall=1 during the FLUSH cycles -> no second pulse. Separately, assert rst during FLUSH -> flush drops to 0 asynchronously and FSM = IDLE.
